// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_sched
// Purpose  : Two-requester round-robin scheduler in front of a shared ALU.
//            Captures one operation, runs it on the ALU (single-cycle or
//            MUL_LAT-cycle multiply), returns a one-cycle response pulse to
//            the granted requester and maintains architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sched #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [7:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [7:0]  req1_shamt,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_lo,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_lo,
  output logic        rsp1_zero,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [7:0]  alu_shamt,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  input  logic        alu_zero,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        last_grant;
  logic        gid;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [7:0]  shamt_q;
  logic [3:0]  cnt;
  logic [31:0] res_lo;
  logic        res_zero;

  logic any_valid;
  logic grant_sel;
  logic handshake;
  logic is_mul;
  logic exec_done;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_sel = ~last_grant;
    else                          grant_sel = req1_valid;
    handshake = (state == S_IDLE) && any_valid;
    is_mul    = (op_q[3:1] == 3'b011);
    exec_done = (state == S_EXEC) && (!is_mul || (cnt == 4'd0));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP when the ALU result is final.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_valid) state_nxt = S_EXEC;
      S_EXEC:  if (exec_done) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: ready only in IDLE for the winner, response pulse only in RESP.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != S_IDLE);
    if (state == S_IDLE && any_valid) begin
      req0_ready = ~grant_sel;
      req1_ready = grant_sel;
    end
    if (state == S_RESP) begin
      rsp0_valid = ~gid;
      rsp1_valid = gid;
    end
  end

  // Operand capture, multiply countdown, result and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gid        <= 1'b0;
      op_q       <= 4'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      shamt_q    <= 8'd0;
      cnt        <= 4'd0;
      res_lo     <= 32'd0;
      res_zero   <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      if (handshake) begin
        gid        <= grant_sel;
        last_grant <= grant_sel;
        op_q       <= grant_sel ? req1_op    : req0_op;
        a_q        <= grant_sel ? req1_a     : req0_a;
        b_q        <= grant_sel ? req1_b     : req0_b;
        shamt_q    <= grant_sel ? req1_shamt : req0_shamt;
        cnt        <= MUL_LOAD;
      end
      if (state == S_EXEC) begin
        if (exec_done) begin
          res_lo   <= alu_lo;
          res_zero <= alu_zero;
          if (is_mul) begin
            hi_q <= alu_hi;
            lo_q <= alu_lo;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  // The ALU always sees the captured operands; results are shared by both requesters.
  always_comb begin
    alu_op    = op_q;
    alu_a     = a_q;
    alu_b     = b_q;
    alu_shamt = shamt_q;
    rsp0_lo   = res_lo;
    rsp0_zero = res_zero;
    rsp1_lo   = res_lo;
    rsp1_zero = res_zero;
  end

endmodule
`default_nettype wire

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: MUL_LAT, default 3, cycles the shared ALU needs for a multiply result (legal 1..15).
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  requester N (N=0,1) has an operation pending.
- reqN_ready  out  1  requester N accepted this cycle.
- reqN_op  in  4  ALU opcode.
- reqN_a, reqN_b  in  32  operands.
- reqN_shamt  in  8  shift amount.
- rspN_valid  out  1  one-cycle result pulse to requester N.
- rspN_lo  out  32  result low word.
- rspN_zero  out  1  result-equals-zero flag.
- alu_op  out  4  to shared ALU.
- alu_a, alu_b  out  32  to shared ALU.
- alu_shamt  out  8  to shared ALU.
- alu_hi, alu_lo  in  32  from shared ALU.
- alu_zero  in  1  from shared ALU.
- hi_q, lo_q  out  32  architectural HI/LO registers.
- busy  out  1  state is not IDLE.

Function
REQ-003 FSM states: IDLE, EXEC, RESP.
REQ-004 IDLE: if any reqN_valid, grant exactly one, assert that reqN_ready combinationally, capture op/a/b/shamt and grant id into operand registers, go to EXEC. Otherwise stay in IDLE.
REQ-005 reqN_ready SHALL be 0 outside IDLE and for the non-granted requester.
REQ-006 Requesters hold valid and payload stable until ready. The block does not check this.
REQ-007 Arbitration is round-robin on last_grant:
- Only one valid: that requester wins.
- Both valid: the requester other than last_grant wins.
- last_grant updates on each handshake.
REQ-008 alu_op/a/b/shamt SHALL be driven from the operand registers in every state. They hold their last values in IDLE/RESP.
REQ-009 Multiply ops are 4'b0110 (signed) and 4'b0111 (unsigned). All other opcodes are single-cycle.
REQ-010 EXEC, single-cycle op: capture alu_lo and alu_zero into the result registers on the first EXEC cycle, go to RESP.
REQ-011 EXEC, multiply op:
- A 4-bit counter loads MUL_LAT-1 on handshake and decrements each EXEC cycle.
- At count 0: capture alu_lo/alu_zero into the result registers, write hi_q<=alu_hi and lo_q<=alu_lo, go to RESP.
- EXEC lasts exactly MUL_LAT cycles.
REQ-012 Non-multiply ops SHALL NOT modify hi_q/lo_q.
REQ-013 RESP:
- Assert rspN_valid for exactly one cycle, for the granted N only.
- Present result on rspN_lo/rspN_zero.
- Go to IDLE. No request is accepted in RESP.
REQ-014 rspN_lo/rspN_zero SHALL hold the last result registers when rspN_valid=0.
REQ-015 Latency from handshake cycle T:
- Single-cycle op: rsp valid in cycle T+2.
- Multiply: rsp valid in cycle T+MUL_LAT+1.
- Minimum issue interval: 3 cycles.
REQ-016 A request arriving while busy waits, with ready=0, until the next IDLE cycle. It is then arbitrated per REQ-007.

Reset
REQ-017 rst_n low asynchronously forces:
- state IDLE, last_grant=1 (so requester 0 wins first);
- counter, operand registers, result registers, hi_q, lo_q = 0;
- rspN_valid=0, busy=0.
REQ-018 Reset during EXEC or RESP discards the operation: no rsp pulse, no HI/LO write. The first accept is possible in the first clock edge after rst_n rises.

Verification
REQ-019 Scenarios, with the bench instantiating the team ALU on the alu_* ports and MUL_LAT=3:
- Reset, no valids -> all outputs 0, busy=0, readys 0.
- req0 add (op 4'b0100) a=5 b=7 at T -> req0_ready at T; rsp0_valid only in T+2 with rsp0_lo=12, rsp0_zero=0; hi_q=lo_q=0.
- req1 sub (op 4'b0101) a=b=9 -> rsp1_valid at T+2, rsp1_lo=0, rsp1_zero=1; rsp0_valid stays 0.
- req0 and req1 valid in the same cycle after reset -> req0 granted first, req1 granted in the IDLE cycle after rsp0_valid. A third simultaneous pair is granted req0 first again.
- req1 signed mult (op 4'b0110) a=0xFFFFFFFE b=3 at T -> rsp1_valid at T+4, rsp1_lo=0xFFFFFFFA, hi_q=0xFFFFFFFF, lo_q=0xFFFFFFFA.
- Unsigned mult issued, rst_n pulsed low at T+2 -> no rsp pulse, hi_q=lo_q=0, busy=0. A new request is accepted after release.
